irq_pending_latch: RTL and testbench

Upstream stage of the 16-input priority encoder. It rising-edge-detects 16 interrupt lines, holds each event as a sticky pending bit until software or the consumer acknowledges it by index, and applies a mask. It drives the encoder's `encoder_in` vector and `enable` from registers. It also flags events lost because a line re-fired while still pending.

---
 rtl/irq_pkg.sv | 13 +
 rtl/irq_edge_detect.sv | 18 +
 rtl/irq_pending_latch.sv | 50 +++++
 tb/tb_irq_pending_latch.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared sizing for the interrupt front end and the downstream priority encoder.
package irq_pkg;
    localparam int N_IRQ        = 16;
    localparam int IDX_W        = 4;
    localparam int IRQ_RSVD_BIT = 0;

    // Bit 0 doubles as the encoder's "nothing pending" code, so it never latches.
    localparam logic [N_IRQ-1:0] IRQ_LIVE = ~(N_IRQ'(1) << IRQ_RSVD_BIT);

    function automatic logic [N_IRQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        return N_IRQ'(1) << idx;
    endfunction
endpackage

// File: rtl/irq_edge_detect.sv
// Rising-edge detector; a line high at reset release counts as an edge.
module irq_edge_detect #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] rise
);
    logic [W-1:0] irq_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) irq_q <= '0;
        else          irq_q <= din;
    end

    assign rise = din & ~irq_q;
endmodule

// File: rtl/irq_pending_latch.sv
// Sticky pending/overflow latch with masked, registered presentation to the encoder.
module irq_pending_latch
    import irq_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic [N_IRQ-1:0] irq_mask,
    input  logic             global_en,
    input  logic             ack_valid,
    input  logic [IDX_W-1:0] ack_idx,
    output logic [N_IRQ-1:0] encoder_in,
    output logic             enable,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] overflow
);
    logic [N_IRQ-1:0] rise, evt, clr, vis, pending_d, overflow_d;

    irq_edge_detect #(.W(N_IRQ)) u_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (irq_in),
        .rise    (rise)
    );

    always_comb begin
        evt = rise & IRQ_LIVE;
        clr = '0;
        if (ack_valid) clr = idx_onehot(ack_idx) & IRQ_LIVE;
        // A fresh edge in the ack cycle re-pends without counting as lost.
        pending_d  = ((pending & ~clr) | evt) & IRQ_LIVE;
        overflow_d = ((overflow & ~clr) | (evt & pending & ~clr)) & IRQ_LIVE;
    end

    assign vis = pending & ~irq_mask;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending    <= '0;
            overflow   <= '0;
            encoder_in <= '0;
            enable     <= 1'b0;
        end else begin
            pending    <= pending_d;
            overflow   <= overflow_d;
            encoder_in <= vis;
            enable     <= global_en & (|vis);
        end
    end
endmodule

// File: tb/tb_irq_pending_latch.sv
// Randomised and directed checks of irq_pending_latch against a per-line event model.
module tb_irq_pending_latch;
    import irq_pkg::*;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [N_IRQ-1:0] irq_in, irq_mask;
    logic             global_en, ack_valid;
    logic [IDX_W-1:0] ack_idx;
    logic [N_IRQ-1:0] encoder_in, pending, overflow;
    logic             enable;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: one flag per line, plus what the line looked like last cycle.
    bit m_pend [N_IRQ];
    bit m_ovf  [N_IRQ];
    bit m_enc  [N_IRQ];
    bit m_prev [N_IRQ];
    bit m_en;

    always #5 clk = ~clk;

    irq_pending_latch dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .irq_in     (irq_in),
        .irq_mask   (irq_mask),
        .global_en  (global_en),
        .ack_valid  (ack_valid),
        .ack_idx    (ack_idx),
        .encoder_in (encoder_in),
        .enable     (enable),
        .pending    (pending),
        .overflow   (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [N_IRQ-1:0] pack(input bit v [N_IRQ]);
        logic [N_IRQ-1:0] r;
        for (int i = 0; i < N_IRQ; i++) r[i] = v[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_IRQ; i++) begin
            m_pend[i] = 0; m_ovf[i] = 0; m_enc[i] = 0; m_prev[i] = 0;
        end
        m_en = 0;
    endtask

    // Advance the model by one clock from the inputs currently applied.
    task automatic model_clock();
        bit any_vis;
        any_vis = 0;
        for (int i = 0; i < N_IRQ; i++) begin
            bit fired, acked, vis;
            vis     = m_pend[i] && !irq_mask[i];
            any_vis = any_vis || vis;
            m_enc[i] = vis;
            fired = (i != 0) && irq_in[i] && !m_prev[i];
            acked = (i != 0) && ack_valid && (int'(ack_idx) == i);
            if (acked)            m_ovf[i] = 0;
            else if (fired && m_pend[i]) m_ovf[i] = 1;
            if (fired)      m_pend[i] = 1;
            else if (acked) m_pend[i] = 0;
            m_prev[i] = irq_in[i];
        end
        m_en = global_en && any_vis;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pending"},  32'(pending),    32'(pack(m_pend)));
        chk({tag, ".overflow"}, 32'(overflow),   32'(pack(m_ovf)));
        chk({tag, ".enc"},      32'(encoder_in), 32'(pack(m_enc)));
        chk({tag, ".enable"},   32'(enable),     32'(m_en));
    endtask

    task automatic step(input logic [N_IRQ-1:0] irq, input logic [N_IRQ-1:0] msk,
                        input logic gen, input logic av, input logic [IDX_W-1:0] idx);
        irq_in = irq; irq_mask = msk; global_en = gen; ack_valid = av; ack_idx = idx;
        @(posedge clk);
        model_clock();
        #1;
        check_all("step");
    endtask

    initial begin
        reset_n = 1'b0; irq_in = 16'h0004; irq_mask = '0; global_en = 1'b1;
        ack_valid = 1'b0; ack_idx = '0;
        model_reset();
        #2;
        chk("rst.pending",  32'(pending),    32'h0);
        chk("rst.overflow", 32'(overflow),   32'h0);
        chk("rst.enc",      32'(encoder_in), 32'h0);
        chk("rst.enable",   32'(enable),     32'h0);
        @(negedge clk); reset_n = 1'b1;

        // Line held high through reset release.
        step(16'h0004, '0, 1, 0, 0);
        chk("rel.pending", 32'(pending), 32'h0004);
        chk("rel.enable1", 32'(enable), 32'h0);
        step(16'h0004, '0, 1, 0, 0);
        chk("rel.enc", 32'(encoder_in), 32'h0004);
        chk("rel.enable2", 32'(enable), 32'h1);
        step(16'h0000, '0, 1, 1, 2);
        step(16'h0000, '0, 1, 0, 0);

        // Double pulse on line 5 -> overflow, then ack.
        step(16'h0020, '0, 1, 0, 0);
        step(16'h0000, '0, 1, 0, 0);
        step(16'h0020, '0, 1, 0, 0);
        chk("ovf5.pending", 32'(pending[5]), 32'h1);
        chk("ovf5.overflow", 32'(overflow[5]), 32'h1);
        step(16'h0000, '0, 1, 1, 5);
        chk("ack5.pending", 32'(pending[5]), 32'h0);
        chk("ack5.overflow", 32'(overflow[5]), 32'h0);
        chk("ack5.enable_hold", 32'(enable), 32'h1);
        step(16'h0000, '0, 1, 0, 0);
        chk("ack5.enable_drop", 32'(enable), 32'h0);

        // Masked line latches but is hidden until unmasked.
        step(16'h0100, 16'h0100, 1, 0, 0);
        step(16'h0000, 16'h0100, 1, 0, 0);
        chk("mask.pending", 32'(pending), 32'h0100);
        chk("mask.enc", 32'(encoder_in), 32'h0);
        chk("mask.enable", 32'(enable), 32'h0);
        step(16'h0000, 16'h0000, 1, 0, 0);
        chk("unmask.enc", 32'(encoder_in), 32'h0100);
        chk("unmask.enable", 32'(enable), 32'h1);
        step(16'h0000, '0, 1, 1, 8);

        // Edge and ack on line 3 in the same cycle.
        step(16'h0008, '0, 1, 0, 0);
        step(16'h0000, '0, 1, 0, 0);
        step(16'h0008, '0, 1, 1, 3);
        chk("same3.pending", 32'(pending[3]), 32'h1);
        chk("same3.overflow", 32'(overflow[3]), 32'h0);
        step(16'h0000, '0, 1, 1, 3);

        // Reserved bit 0.
        step(16'h0001, '0, 1, 0, 0);
        chk("rsvd.pending0", 32'(pending[0]), 32'h0);
        step(16'h0002, '0, 1, 0, 0);
        step(16'h0000, '0, 1, 1, 0);
        chk("rsvd.ack0", 32'(pending[1]), 32'h1);
        step(16'h0000, '0, 1, 1, 1);

        // global_en drop with lines 2 and 9 pending.
        step(16'h0204, '0, 1, 0, 0);
        step(16'h0000, '0, 1, 0, 0);
        chk("gen.enable_on", 32'(enable), 32'h1);
        step(16'h0000, '0, 0, 0, 0);
        chk("gen.enable_off", 32'(enable), 32'h0);
        chk("gen.pending", 32'(pending), 32'h0204);

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            logic [N_IRQ-1:0] r_irq, r_msk;
            r_irq = N_IRQ'($urandom) & N_IRQ'($urandom) & N_IRQ'($urandom);
            r_msk = N_IRQ'($urandom) & N_IRQ'($urandom);
            step(r_irq, r_msk, ($urandom_range(0, 7) != 0), $urandom_range(0, 1) == 1,
                 IDX_W'($urandom));
        end

        // Asynchronous reset mid-run, away from the clock edge.
        @(negedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("midrst.pending",  32'(pending),    32'h0);
        chk("midrst.overflow", 32'(overflow),   32'h0);
        chk("midrst.enc",      32'(encoder_in), 32'h0);
        chk("midrst.enable",   32'(enable),     32'h0);
        model_reset();
        @(negedge clk); reset_n = 1'b1;
        for (int c = 0; c < 100; c++) begin
            step(N_IRQ'($urandom) & N_IRQ'($urandom), N_IRQ'($urandom) & N_IRQ'($urandom),
                 1'b1, $urandom_range(0, 1) == 1, IDX_W'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
